// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N input channels into one registered output.
// The slave modport is the arbiter side; the master modport is the traffic source/sink.
interface mux_arb_n_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel mux/arbiter with a single registered output stage.
// Fixed-select by default; define MUX_ARB_RR_EN to add round-robin mode and its pointer.
module mux_arb_n #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic      clk,
    input  logic      rst,
    mux_arb_n_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic             load_en;
    logic             xfer;

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    int               rr_idx;
`else
    logic             unused_mode;
    assign unused_mode = bus.mode;
`endif

    // Grant selection; fixed mode grants sel whether or not that channel is valid.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
`ifdef MUX_ARB_RR_EN
        rr_idx  = 0;
        if (bus.mode) begin
            // Scan farthest-first so the channel nearest ptr overwrites last and wins.
            for (int i = N - 1; i >= 0; i--) begin
                rr_idx = int'(ptr_q) + i;
                if (rr_idx >= N) rr_idx = rr_idx - N;
                if (bus.in_valid[SEL_W'(rr_idx)]) begin
                    gnt     = SEL_W'(rr_idx);
                    gnt_vld = 1'b1;
                end
            end
        end else
`endif
        begin
            for (int k = 0; k < N; k++) begin
                if (bus.sel == SEL_W'(k)) begin
                    gnt     = SEL_W'(k);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = !rst && gnt_vld && load_en && bus.in_valid[gnt];

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < N; k++) begin
            bus.in_ready[k] = !rst && gnt_vld && load_en && (gnt == SEL_W'(k));
        end
    end

    always_comb begin
        out_valid_d = xfer || (out_valid_q && !bus.out_ready);
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_data_d = bus.in_data[int'(gnt)*WIDTH +: WIDTH];
            out_src_d  = gnt;
        end
    end

`ifdef MUX_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && bus.mode) begin
            ptr_d = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef MUX_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: directed vectors push expected words, a negedge
// monitor pops and compares each word the DUT delivers downstream.
module tb_mux_arb_n;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_arb_n_if #(.WIDTH(W), .N(N)) bus ();
    mux_arb_n #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [N*W-1:0] D_K5 = 16'h8765;   // channel k carries k+5
`ifdef MUX_ARB_RR_EN
    localparam logic [N-1:0] ER_IDLE = 4'b0000;
`else
    localparam logic [N-1:0] ER_IDLE = 4'b0100;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; expected in_ready is hand-computed per vector.
    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [SW-1:0] s,
                       input logic m, input logic ordy, input logic [N-1:0] er,
                       input logic [W-1:0] ed, input logic [SW-1:0] es);
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sel       = s;
        bus.mode      = m;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", int'(bus.in_ready), int'(er));
        if ((v & er) != '0) begin
            e.d = ed;
            e.s = es;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got src %0d data %0h, required no word", bus.out_src, bus.out_data);
            end else begin
                e = q.pop_front();
                chk("out_data", int'(bus.out_data), int'(e.d));
                chk("out_src", int'(bus.out_src), int'(e.s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = '1;
        bus.in_data   = '0;
        bus.sel       = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_src", int'(bus.out_src), 0);
        rst = 1'b0;
        bus.in_valid = '0;

        // Fixed select of ch2, then drain
        cyc(4'b0100, 16'h0A00, 2'd2, 1'b0, 1'b1, 4'b0100, 4'hA, 2'd2);
        cyc(4'b0000, 16'h0A00, 2'd2, 1'b0, 1'b1, 4'b0100, 4'h0, 2'd0);

        // Backpressure: held word must not change when sel/data move
        cyc(4'b0010, 16'h0030, 2'd1, 1'b0, 1'b0, 4'b0010, 4'h3, 2'd1);
        cyc(4'b1000, 16'h9030, 2'd3, 1'b0, 1'b0, 4'b0000, 4'h0, 2'd0);
        chk("hold_data", int'(bus.out_data), 3);
        chk("hold_src", int'(bus.out_src), 1);
        cyc(4'b1000, 16'h9030, 2'd3, 1'b0, 1'b0, 4'b0000, 4'h0, 2'd0);
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data2", int'(bus.out_data), 3);
        cyc(4'b1000, 16'h9030, 2'd3, 1'b0, 1'b1, 4'b1000, 4'h9, 2'd3);
        cyc(4'b0000, 16'h9030, 2'd3, 1'b0, 1'b1, 4'b1000, 4'h0, 2'd0);
        cyc(4'b0000, 16'h9030, 2'd3, 1'b0, 1'b1, 4'b1000, 4'h0, 2'd0);
        chk("drained_valid", int'(bus.out_valid), 0);
        chk("drained_data", int'(bus.out_data), 9);

`ifdef MUX_ARB_RR_EN
        // Round-robin over all-valid channels, back to back
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0001, 4'h5, 2'd0);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0010, 4'h6, 2'd1);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b1000, 4'h8, 2'd3);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0001, 4'h5, 2'd0);
        // ptr=1, sparse valids: 3, 0, 3; then idle keeps ptr at 0
        cyc(4'b1001, D_K5, 2'd2, 1'b1, 1'b1, 4'b1000, 4'h8, 2'd3);
        cyc(4'b1001, D_K5, 2'd2, 1'b1, 1'b1, 4'b0001, 4'h5, 2'd0);
        cyc(4'b1001, D_K5, 2'd2, 1'b1, 1'b1, 4'b1000, 4'h8, 2'd3);
        cyc(4'b0000, D_K5, 2'd2, 1'b1, 1'b1, 4'b0000, 4'h0, 2'd0);
        cyc(4'b0000, D_K5, 2'd2, 1'b1, 1'b1, 4'b0000, 4'h0, 2'd0);
        chk("rr_drop_valid", int'(bus.out_valid), 0);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0001, 4'h5, 2'd0);
        cyc(4'b0000, D_K5, 2'd2, 1'b1, 1'b1, 4'b0000, 4'h0, 2'd0);
        // ptr now 1: capture ch1 and hold it
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b0, 4'b0010, 4'h6, 2'd1);
`else
        // mode ignored: ch2 every cycle
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
        cyc(4'b0000, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h0, 2'd0);
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b0, 4'b0100, 4'h7, 2'd2);
`endif
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b0, 4'b0000, 4'h0, 2'd0);

        // Reset with a held word and a pending request: the word is discarded
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", int'(bus.in_ready), 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = '0;
        chk("rst_mid_out_valid", int'(bus.out_valid), 0);
        chk("rst_mid_out_data", int'(bus.out_data), 0);
        chk("rst_mid_out_src", int'(bus.out_src), 0);
`ifdef MUX_ARB_RR_EN
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0001, 4'h5, 2'd0);
`else
        cyc(4'b1111, D_K5, 2'd2, 1'b1, 1'b1, 4'b0100, 4'h7, 2'd2);
`endif
        repeat (3) cyc(4'b0000, D_K5, 2'd2, 1'b1, 1'b1, ER_IDLE, 4'h0, 2'd0);
        chk("sb_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
